convolucion_param: RTL and testbench

Parametrised 1-D linear convolution engine, z[i] = sum over k of y[k]*h[i-k], i = 0..sizeY+sizeH-2.
- Kernel h is loaded at runtime into an internal register file; no fixed ROM contents.
- y is read from an external asynchronous memory; z samples stream out over a ready/valid write port.
- Runtime signed/unsigned mode; only valid (k, i-k) pairs are visited, one MAC per cycle.

---
 rtl/convolucion_param.sv | 182 ++++++++++++++++++
 tb/tb_convolucion_param.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/convolucion_param.sv
// 1-D linear convolution z = y * h, one MAC per cycle, kernel in an internal register file.
// Define CONV_SATURATE_EN to clamp z samples to OUT_WIDTH instead of truncating them.
module convolucion_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int OUT_WIDTH    = 16,
  parameter int ADDR_Y_WIDTH = 5,
  parameter int ADDR_H_WIDTH = 5,
  parameter int ADDR_Z_WIDTH = 6,
  parameter int ACC_WIDTH    = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    signed_i,
  input  logic [ADDR_Y_WIDTH:0]   size_y_i,
  input  logic [ADDR_H_WIDTH:0]   size_h_i,
  input  logic                    h_we_i,
  input  logic [ADDR_H_WIDTH-1:0] h_addr_i,
  input  logic [DATA_WIDTH-1:0]   h_data_i,
  output logic [ADDR_Y_WIDTH-1:0] mem_y_addr_o,
  input  logic [DATA_WIDTH-1:0]   data_y_i,
  output logic [OUT_WIDTH-1:0]    data_z_o,
  output logic [ADDR_Z_WIDTH-1:0] mem_z_addr_o,
  output logic                    write_o,
  input  logic                    z_ready_i,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_INIT, S_MAC, S_OUT, S_DONE} state_t;

  localparam int CW = ADDR_Z_WIDTH + 1;
  localparam int PW = 2 * DATA_WIDTH + 2;
  localparam logic [ADDR_Y_WIDTH:0] MAX_Y = {1'b1, {ADDR_Y_WIDTH{1'b0}}};
  localparam logic [ADDR_H_WIDTH:0] MAX_H = {1'b1, {ADDR_H_WIDTH{1'b0}}};

  state_t                  state_q, state_d;
  logic [ADDR_Y_WIDTH:0]   size_y_q, size_y_d;
  logic [ADDR_H_WIDTH:0]   size_h_q, size_h_d;
  logic [ADDR_Z_WIDTH-1:0] size_z_q, size_z_d;
  logic                    signed_q, signed_d;
  logic [ADDR_Z_WIDTH-1:0] i_q, i_d;
  logic [ADDR_Y_WIDTH-1:0] k_q, k_d;
  logic [ADDR_Y_WIDTH-1:0] k_end_q, k_end_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;

  logic [DATA_WIDTH-1:0]   h_mem [2**ADDR_H_WIDTH];
  logic [ADDR_H_WIDTH-1:0] h_idx;
  logic signed [DATA_WIDTH:0] y_ext, h_ext;
  logic signed [PW-1:0]    prod;
  logic [ACC_WIDTH-1:0]    prod_ext;
  logic [CW-1:0]           i_w, sy_w, sh_w, ks_w, ke_w;
  logic                    size_ok;
  logic [OUT_WIDTH-1:0]    z_val;

  always_ff @(posedge clk) begin
    if (h_we_i && !busy_o) begin
      h_mem[h_addr_i] <= h_data_i;
    end
  end

  // Operands get one extra bit so the same signed multiplier serves both modes.
  assign h_idx    = ADDR_H_WIDTH'(i_q - ADDR_Z_WIDTH'(k_q));
  assign y_ext    = {signed_q & data_y_i[DATA_WIDTH-1], data_y_i};
  assign h_ext    = {signed_q & h_mem[h_idx][DATA_WIDTH-1], h_mem[h_idx]};
  assign prod     = PW'(y_ext) * PW'(h_ext);
  assign prod_ext = ACC_WIDTH'(prod);

  assign size_ok = (size_y_i != '0) && (size_y_i <= MAX_Y) &&
                   (size_h_i != '0) && (size_h_i <= MAX_H);

  always_comb begin
    i_w  = CW'(i_q);
    sy_w = CW'(size_y_q);
    sh_w = CW'(size_h_q);
    ks_w = (i_w >= sh_w) ? (i_w - sh_w + CW'(1)) : '0;
    ke_w = (i_w < sy_w) ? i_w : (sy_w - CW'(1));
  end

  always_comb begin
    state_d  = state_q;
    size_y_d = size_y_q;
    size_h_d = size_h_q;
    size_z_d = size_z_q;
    signed_d = signed_q;
    i_d      = i_q;
    k_d      = k_q;
    k_end_d  = k_end_q;
    acc_d    = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          size_y_d = size_y_i;
          size_h_d = size_h_i;
          signed_d = signed_i;
          state_d  = size_ok ? S_SETUP : S_DONE;
        end
      end
      S_SETUP: begin
        size_z_d = ADDR_Z_WIDTH'(size_y_q) + ADDR_Z_WIDTH'(size_h_q) - ADDR_Z_WIDTH'(1);
        i_d      = '0;
        state_d  = S_INIT;
      end
      S_INIT: begin
        k_d     = ADDR_Y_WIDTH'(ks_w);
        k_end_d = ADDR_Y_WIDTH'(ke_w);
        acc_d   = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        if (k_q == k_end_q) begin
          state_d = S_OUT;
        end else begin
          k_d = k_q + ADDR_Y_WIDTH'(1);
        end
      end
      S_OUT: begin
        if (z_ready_i) begin
          if (i_q == size_z_q - ADDR_Z_WIDTH'(1)) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q + ADDR_Z_WIDTH'(1);
            state_d = S_INIT;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      size_y_q <= '0;
      size_h_q <= '0;
      size_z_q <= '0;
      signed_q <= 1'b0;
      i_q      <= '0;
      k_q      <= '0;
      k_end_q  <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      size_y_q <= size_y_d;
      size_h_q <= size_h_d;
      size_z_q <= size_z_d;
      signed_q <= signed_d;
      i_q      <= i_d;
      k_q      <= k_d;
      k_end_q  <= k_end_d;
      acc_q    <= acc_d;
    end
  end

`ifdef CONV_SATURATE_EN
  // Overflow shows up as upper accumulator bits that disagree with the kept sign/range.
  always_comb begin
    z_val = acc_q[OUT_WIDTH-1:0];
    if (signed_q) begin
      if (!((&acc_q[ACC_WIDTH-1:OUT_WIDTH-1]) || !(|acc_q[ACC_WIDTH-1:OUT_WIDTH-1]))) begin
        z_val = acc_q[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                   : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end else if (|acc_q[ACC_WIDTH-1:OUT_WIDTH]) begin
      z_val = '1;
    end
  end
`else
  assign z_val = OUT_WIDTH'(acc_q);
`endif

  assign busy_o       = (state_q == S_SETUP) || (state_q == S_INIT) ||
                        (state_q == S_MAC)   || (state_q == S_OUT);
  assign write_o      = (state_q == S_OUT);
  assign done_o       = (state_q == S_DONE);
  assign mem_y_addr_o = (state_q == S_MAC) ? k_q : '0;
  assign mem_z_addr_o = write_o ? i_q : '0;
  assign data_z_o     = write_o ? z_val : '0;

endmodule

// File: tb/tb_convolucion_param.sv
// Directed self-checking bench for convolucion_param; honours CONV_SATURATE_EN for expected values.
module tb_convolucion_param;

  localparam int DW = 8;
  localparam int OW = 16;
  localparam int AY = 5;
  localparam int AH = 5;
  localparam int AZ = 6;
  localparam int AW = 21;

`ifdef CONV_SATURATE_EN
  localparam logic [OW-1:0] Z1_32  = 16'hFFFF;
  localparam logic [OW-1:0] Z31_32 = 16'hFFFF;
`else
  localparam logic [OW-1:0] Z1_32  = 16'hFC02;
  localparam logic [OW-1:0] Z31_32 = 16'hC020;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          signed_i;
  logic [AY:0]   size_y_i;
  logic [AH:0]   size_h_i;
  logic          h_we_i;
  logic [AH-1:0] h_addr_i;
  logic [DW-1:0] h_data_i;
  logic [AY-1:0] mem_y_addr_o;
  logic [DW-1:0] data_y_i;
  logic [OW-1:0] data_z_o;
  logic [AZ-1:0] mem_z_addr_o;
  logic          write_o;
  logic          z_ready_i;
  logic          busy_o;
  logic          done_o;

  logic [DW-1:0] y_mem [2**AY];
  logic [AZ-1:0] wa_q[$];
  logic [OW-1:0] wd_q[$];
  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int start_cyc = 0;
  int done_cnt  = 0;
  int write_cnt = 0;

  convolucion_param #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .ADDR_Y_WIDTH(AY),
    .ADDR_H_WIDTH(AH), .ADDR_Z_WIDTH(AZ), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .size_y_i(size_y_i), .size_h_i(size_h_i), .h_we_i(h_we_i),
    .h_addr_i(h_addr_i), .h_data_i(h_data_i), .mem_y_addr_o(mem_y_addr_o),
    .data_y_i(data_y_i), .data_z_o(data_z_o), .mem_z_addr_o(mem_z_addr_o),
    .write_o(write_o), .z_ready_i(z_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  assign data_y_i = y_mem[mem_y_addr_o];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (write_o) write_cnt++;
    if (write_o && z_ready_i) begin
      wa_q.push_back(mem_z_addr_o);
      wd_q.push_back(data_z_o);
      $display("write z[%0d] = %h", mem_z_addr_o, data_z_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle count from the start edge to the edge that enters DONE.
  function automatic int exp_lat(input int sy, input int sh);
    int sum = 1;
    for (int i = 0; i <= sy + sh - 2; i++) begin
      int ks = (i - sh + 1 > 0) ? i - sh + 1 : 0;
      int ke = (i < sy - 1) ? i : sy - 1;
      sum += 2 + ke - ks + 1;
    end
    return sum;
  endfunction

  task automatic load_h(input int idx, input logic [DW-1:0] v);
    @(posedge clk); #1;
    h_we_i   = 1'b1;
    h_addr_i = idx[AH-1:0];
    h_data_i = v;
    @(posedge clk); #1;
    h_we_i   = 1'b0;
  endtask

  task automatic start_op(input int sy, input int sh, input bit sgn);
    @(posedge clk); #1;
    size_y_i = sy[AY:0];
    size_h_i = sh[AH:0];
    signed_i = sgn;
    start_i  = 1'b1;
    wa_q.delete();
    wd_q.delete();
    @(posedge clk); #1;
    start_cyc = cyc;
    start_i   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_edges);
    bit seen = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, cyc - start_cyc, exp_edges);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
  endtask

  task automatic check_z(input string tag, input int idx, input logic [OW-1:0] exp);
    if (idx < wd_q.size()) begin
      check({tag, "_addr"}, 32'(wa_q[idx]), idx);
      check({tag, "_data"}, 32'(wd_q[idx]), 32'(exp));
    end else begin
      check({tag, "_missing"}, wd_q.size(), idx + 1);
    end
  endtask

  task automatic check_simple(input string tag);
    check({tag, "_count"}, wd_q.size(), 4);
    check_z({tag, "_z0"}, 0, 16'h0001);
    check_z({tag, "_z1"}, 1, 16'h0003);
    check_z({tag, "_z2"}, 2, 16'h0005);
    check_z({tag, "_z3"}, 3, 16'h0003);
  endtask

  task automatic wait_write(input int addr, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (write_o && mem_z_addr_o == addr[AZ-1:0]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int wc, dc;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; size_y_i = '0; size_h_i = '0;
    h_we_i = 1'b0; h_addr_i = '0; h_data_i = '0; z_ready_i = 1'b1;
    for (int i = 0; i < 2**AY; i++) y_mem[i] = 8'hFF;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {write_o, busy_o, done_o, data_z_o, mem_z_addr_o, mem_y_addr_o}, 32'd0);
    rst = 1'b0;

    // Basic unsigned run: h = [1,1], y = [1,2,3]
    load_h(0, 8'h01);
    load_h(1, 8'h01);
    y_mem[0] = 8'd1; y_mem[1] = 8'd2; y_mem[2] = 8'd3;
    start_op(3, 2, 1'b0);
    check("busy_after_start", 32'(busy_o), 32'd1);
    wait_done("basic", exp_lat(3, 2));
    check_simple("basic");
    check("idle_busy", 32'(busy_o), 32'd0);

    // Signed run
    load_h(0, 8'h03);
    load_h(1, 8'hFC);
    y_mem[0] = 8'hFF; y_mem[1] = 8'h02;
    start_op(2, 2, 1'b1);
    wait_done("signed", exp_lat(2, 2));
    check("signed_count", wd_q.size(), 3);
    check_z("signed_z0", 0, 16'hFFFD);
    check_z("signed_z1", 1, 16'h000A);
    check_z("signed_z2", 2, 16'hFFF8);

    // Full-size run, all 0xFF unsigned
    for (int i = 0; i < 2**AH; i++) load_h(i, 8'hFF);
    for (int i = 0; i < 2**AY; i++) y_mem[i] = 8'hFF;
    start_op(32, 32, 1'b0);
    wait_done("full", exp_lat(32, 32));
    check("full_count", wd_q.size(), 63);
    check_z("full_z0", 0, 16'hFE01);
    check_z("full_z1", 1, Z1_32);
    check_z("full_z31", 31, Z31_32);
    check_z("full_z62", 62, 16'hFE01);

    // Backpressure during OUT of z[1]
    load_h(0, 8'h01);
    load_h(1, 8'h01);
    y_mem[0] = 8'd1; y_mem[1] = 8'd2; y_mem[2] = 8'd3;
    start_op(3, 2, 1'b0);
    wait_write(0, ok);
    check("bp_z0_seen", 32'(ok), 32'd1);
    @(posedge clk); #1;
    z_ready_i = 1'b0;
    wait_write(1, ok);
    check("bp_z1_seen", 32'(ok), 32'd1);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge clk);
      check("bp_hold_write", 32'(write_o), 32'd1);
      check("bp_hold_addr", 32'(mem_z_addr_o), 32'd1);
      check("bp_hold_data", 32'(data_z_o), 32'h0003);
    end
    @(posedge clk); #1;
    z_ready_i = 1'b1;
    wait_done("bp", exp_lat(3, 2) + 3);
    check_simple("bp");

    // Illegal sizes finish immediately without writes
    wc = write_cnt;
    start_op(3, 0, 1'b0);
    wait_done("size_h0", 0);
    check("size_h0_no_write", write_cnt - wc, 0);
    wc = write_cnt;
    start_op(33, 2, 1'b0);
    wait_done("size_y33", 0);
    check("size_y33_no_write", write_cnt - wc, 0);

    // Kernel write and start pulse while busy are ignored
    start_op(3, 2, 1'b0);
    h_we_i = 1'b1; h_addr_i = '0; h_data_i = 8'h55; start_i = 1'b1;
    @(posedge clk); #1;
    h_we_i = 1'b0; start_i = 1'b0;
    wait_done("busy_ign", exp_lat(3, 2));
    check_simple("busy_ign");
    start_op(3, 2, 1'b0);
    wait_done("busy_ign2", exp_lat(3, 2));
    check_simple("busy_ign2");

    // Reset in the middle of a full-size run
    dc = done_cnt;
    start_op(32, 32, 1'b0);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (mem_y_addr_o == 5'd5) begin
        ok = 1'b1;
        break;
      end
    end
    check("midrst_mac_reached", 32'(ok), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_outputs", {write_o, busy_o, done_o, data_z_o, mem_z_addr_o, mem_y_addr_o}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_no_done", done_cnt - dc, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    start_op(3, 2, 1'b0);
    wait_done("after_rst", exp_lat(3, 2));
    check_simple("after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
